proc_io_bridge: RTL
===================

Name: proc_io_bridge

Overview:
- I/O responder on the far side of the processor core's I/O bus (io_in/addr_in/req_in for reads, io_out/addr_out/out_en for writes).
- Maps processor I/O addresses onto:
  - an RX FIFO, filled from an upstream valid/ready sample stream;
  - a TX FIFO, drained to a downstream valid/ready stream;
  - status and control words;
  - general-purpose in/out registers.
- Lets firmware on the processor exchange buffered sample streams with the rest of the FPGA.

Parameters:
- NUBITS, 16, data width; must be >= 16.
- NUIOIN, 8, number of input addresses; must be >= 3.
- NUIOOU, 8, number of output addresses; must be >= 3.
- FDEPTH, 8, depth of each FIFO; power of 2, 2..256.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- io_out  in  NUBITS  processor write data.
- addr_out  in  clog2(NUIOOU)  processor write address.
- out_en  in  1  processor write strobe, one cycle per write.
- addr_in  in  clog2(NUIOIN)  processor read address.
- req_in  in  1  processor read strobe, one cycle per read.
- io_in  out  NUBITS  read data returned to processor.
- s_data  in  NUBITS  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  RX FIFO can accept.
- m_data  out  NUBITS  TX FIFO head.
- m_valid  out  1  TX FIFO not empty.
- m_ready  in  1  downstream accepts.
- gp_in  in  NUBITS*NUIOIN  general inputs; slice k is read at address k, for k >= 2.
- gp_out  out  NUBITS*NUIOOU  general output registers; slice k is written at address k, for k >= 2. Slices 0 and 1 are tied to 0.

Behaviour:
- Reset (rst=0 at a clock edge):
  - both FIFOs empty, sticky flags cleared, gp_out all 0;
  - therefore s_ready=1, m_valid=0, m_data=0.
  - The FIFO memory contents are don't-care.
  - A reset asserted mid-transfer discards all buffered data; no handshake completes in that cycle.

- Read path (combinational, zero latency): io_in is selected by addr_in in the same cycle.
  - addr 0: RX head; reads 0 when RX is empty.
  - addr 1: status word:
    - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full;
    - bit4 rx_underflow (sticky), bit5 tx_overflow (sticky);
    - bits[15:8] RX occupancy;
    - other bits 0.
  - addr >= 2: gp_in slice addr.
- RX pop: occurs at the clock edge where req_in=1, addr_in=0 and RX is non-empty.
  - req_in=1, addr_in=0 with RX empty: no pop; rx_underflow set to 1.
  - Reads at other addresses have no side effects.

- Write path (takes effect at the clock edge where out_en=1):
  - addr 0: push io_out into TX if TX is not full. If TX is full, the data is dropped and tx_overflow is set.
  - addr 1: control word, which is not stored:
    - bit0 flushes RX;
    - bit1 flushes TX;
    - bit2 clears both sticky flags.
  - addr >= 2: gp_out slice addr <= io_out.

- RX input handshake:
  - s_ready = !rx_full.
  - Push occurs when s_valid & s_ready.
  - s_ready is derived from the current occupancy only. A full FIFO with a simultaneous pop therefore still refuses the push in that cycle.
- TX output handshake:
  - m_valid = !tx_empty; m_data = TX head.
  - Pop occurs when m_valid & m_ready.
  - m_data must stay stable while m_valid=1 and m_ready=0.

- FIFOs: circular buffers with wrap-around pointers and an explicit occupancy counter.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the occupancy unchanged.
  - Push and pop on an empty FIFO in the same cycle: the push is accepted and the pop is refused.
  - When a flush and push/pop occur in the same cycle, the flush has priority: the FIFO ends empty.
  - When a flag-clear and a new flag-set event occur in the same cycle, the set has priority.
- Occupancy in status bits[15:8] saturates at 255.
- No handshake spans more than one cycle; the processor side never stalls.

Test Plan:
- Reset, then read each address:
  - addr 1 reads 0x0005 (rx_empty, tx_empty);
  - gp_out = 0, m_valid = 0, s_ready = 1.
- RX ordering:
  - Drive s_data 0x0011, 0x0022, 0x0033 with s_valid.
  - Status bits[15:8] = 3.
  - Three reads at addr 0 return 0x0011, 0x0022, 0x0033 in order.
  - The fourth read returns 0 and status bit4 = 1.
- RX full:
  - Push 8 samples (FDEPTH=8): s_ready drops after the 8th.
  - In the following cycle, assert s_valid together with a processor pop. The push is refused, occupancy becomes 7, and s_ready returns to 1 in the next cycle.
- TX ordering and backpressure:
  - Write 0x0A0A, 0x0B0B to addr 0 with m_ready=0: m_valid=1 and m_data holds 0x0A0A.
  - Raise m_ready: 0x0A0A then 0x0B0B are delivered on consecutive cycles.
- TX overflow and clear:
  - 9 writes to addr 0: status bit3 = 1, bit5 = 1, and the 9th word never appears on m_data.
  - Write 0x0004 to addr 1: bit5 clears.
  - Write 0x0003 to addr 1: both FIFOs become empty.
- GP registers, wrap-around and reset:
  - Write 0x1234 to addr 5: gp_out slice 5 = 0x1234.
  - Run 20 push/pop pairs through RX to exercise pointer wrap; data stays in order.
  - Drive rst=0 for one cycle mid-stream: all state returns to reset values.

Source files
------------

// File: rtl/proc_io_bridge.sv
// Processor I/O responder bridging core I/O reads/writes onto an RX FIFO, a TX FIFO,
// status/control words and general-purpose in/out registers.
module proc_io_bridge #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NUIOIN = 8,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned FDEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  input  logic                       req_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic [NUBITS-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [NUBITS-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic [NUBITS*NUIOIN-1:0]   gp_in,
  output logic [NUBITS*NUIOOU-1:0]   gp_out
);

  localparam int unsigned AWI = $clog2(NUIOIN);
  localparam int unsigned AWO = $clog2(NUIOOU);
  localparam int unsigned PW  = $clog2(FDEPTH);
  localparam int unsigned CW  = PW + 1;

  // RX FIFO state
  logic [NUBITS-1:0] rx_mem [FDEPTH];
  logic [PW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;

  // TX FIFO state
  logic [NUBITS-1:0] tx_mem [FDEPTH];
  logic [PW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;

  logic rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
  logic [NUBITS*NUIOOU-1:0] gp_q, gp_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_uf_ev;
  logic tx_wr, tx_push, tx_pop, tx_of_ev;
  logic rd_fifo, wr_ctl, rx_flush, tx_flush, flag_clr;

  logic [NUBITS-1:0] rx_head, status;
  logic [8:0]        rx_occ;
  logic [7:0]        rx_occ_sat;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FDEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(FDEPTH));

  // Control word is a strobe only; nothing of it is stored.
  assign wr_ctl   = out_en && (addr_out == AWO'(1));
  assign rx_flush = wr_ctl & io_out[0];
  assign tx_flush = wr_ctl & io_out[1];
  assign flag_clr = wr_ctl & io_out[2];

  assign rd_fifo  = req_in && (addr_in == AWI'(0));
  assign rx_pop   = rd_fifo & ~rx_empty;
  assign rx_uf_ev = rd_fifo & rx_empty;
  assign rx_push  = s_valid & ~rx_full;

  assign tx_wr    = out_en && (addr_out == AWO'(0));
  assign tx_push  = tx_wr & ~tx_full;
  assign tx_of_ev = tx_wr & tx_full;
  assign tx_pop   = ~tx_empty & m_ready;

  // Handshakes are gated by reset so nothing completes in a reset cycle.
  assign s_ready = rst & ~rx_full;
  assign m_valid = rst & ~tx_empty;
  assign m_data  = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rd_q];
  assign gp_out  = gp_q;

  // Occupancy field is 8 bits wide; saturate for a 256-deep FIFO.
  assign rx_occ     = 9'(rx_cnt_q);
  assign rx_occ_sat = rx_occ[8] ? 8'hFF : rx_occ[7:0];

  always_comb begin
    status       = '0;
    status[0]    = rx_empty;
    status[1]    = rx_full;
    status[2]    = tx_empty;
    status[3]    = tx_full;
    status[4]    = rx_uf_q;
    status[5]    = tx_of_q;
    status[15:8] = rx_occ_sat;
  end

  always_comb begin
    io_in = '0;
    for (int k = 0; k < int'(NUIOIN); k++) begin
      if (addr_in == AWI'(k)) io_in = gp_in[k*NUBITS +: NUBITS];
    end
    if (addr_in == AWI'(0)) begin
      io_in = rx_head;
    end else if (addr_in == AWI'(1)) begin
      io_in = status;
    end
  end

  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end
  end

  // A set event in the same cycle as a clear wins.
  always_comb begin
    rx_uf_d = rx_uf_q;
    tx_of_d = tx_of_q;
    if (flag_clr) begin
      rx_uf_d = 1'b0;
      tx_of_d = 1'b0;
    end
    if (rx_uf_ev) rx_uf_d = 1'b1;
    if (tx_of_ev) tx_of_d = 1'b1;
  end

  always_comb begin
    gp_d = gp_q;
    for (int k = 2; k < int'(NUIOOU); k++) begin
      if (out_en && (addr_out == AWO'(k))) gp_d[k*NUBITS +: NUBITS] = io_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_uf_q  <= 1'b0;
      tx_of_q  <= 1'b0;
      gp_q     <= '0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_uf_q  <= rx_uf_d;
      tx_of_q  <= tx_of_d;
      gp_q     <= gp_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= s_data;
    if (tx_push) tx_mem[tx_wr_q] <= io_out;
  end

endmodule
